mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 23 ++
 rtl/mem_access_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int MEM_WORDS_DEFAULT = 256;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 30;  // word index = byte address >> 2
  localparam int CNT_W  = 3;   // wide enough for RD_LAT up to 7

  // Reject misaligned byte addresses and word indices past the end of memory.
  function automatic logic addr_err(input logic [ADDR_W-1:0] byte_addr,
                                    input int unsigned       words);
    logic [ADDR_W-1:0] idx;
    idx = {{(ADDR_W-IDX_W){1'b0}}, byte_addr[ADDR_W-1:ADDR_W-IDX_W]};
    return (byte_addr[1:0] != 2'b00) || (idx >= words);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU load/store controller in front of a fixed-latency
// data memory. One request is accepted in IDLE, the memory strobes are held
// for RD_LAT+1 cycles, and a one-cycle response pulse closes the access.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       write_data,
  output logic              memread,
  output logic              memwrite,
  input  logic [31:0]       read_data
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_err;

  assign req_err = addr_err(req_addr, MEM_WORDS);

  // Control FSM; every output is a register so the memory sees clean strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      addr       <= '0;
      write_data <= '0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_err) begin
              // Rejected accesses never touch memory.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              // Address/data/direction are latched into the memory-facing
              // registers here and held unchanged for the whole access.
              state      <= ACCESS;
              cnt        <= CNT_W'(RD_LAT);
              addr       <= {{(ADDR_W-IDX_W){1'b0}}, req_addr[ADDR_W-1:ADDR_W-IDX_W]};
              write_data <= req_wdata;
              memread    <= ~req_write;
              memwrite   <= req_write;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            // Last access cycle: read_data has had RD_LAT cycles to settle.
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= memwrite ? '0 : read_data;
            addr       <= '0;
            write_data <= '0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
